display_source_scheduler: RTL and testbench

//   Shares the single 4-digit seven-segment display between up to NUM_SRC value producers.

---
 rtl/display_source_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_display_source_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_scheduler.sv
// Round-robin sharing of a 4-digit display between value sources,
// with urgent pre-emption. Optional SCHED_FREEZE_EN adds a freeze input.
module display_source_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int URGENT_HOLD  = 200_000_000
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic                   urgent_req,
  input  logic [15:0]            urgent_data,
`ifdef SCHED_FREEZE_EN
  input  logic                   freeze,
`endif
  output logic                   urgent_ack,
  output logic [15:0]            displayed_number,
  output logic                   we,
  output logic [1:0]             active_src,
  output logic                   busy_urgent
);

  typedef enum logic [1:0] {IDLE, SHOW, URGENT} state_t;

  localparam logic [31:0] DW_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] UH_LAST = 32'(URGENT_HOLD - 1);

  state_t      state_q, state_d;
  logic [15:0] disp_q, disp_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [1:0]  act_q, act_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] hold_q, hold_d;

  logic        frz;
  logic        any;
  logic [1:0]  nxt;
  logic [1:0]  here;
  logic [15:0] cur;

`ifdef SCHED_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  function automatic logic [15:0] clampv(input logic [15:0] v);
    return (v > 16'd9999) ? 16'd9999 : v;
  endfunction

  function automatic logic [15:0] dat(input logic [1:0] i);
    return clampv(src_data[16*int'(i) +: 16]);
  endfunction

  // first valid index at or after start+off, wrapping
  function automatic logic [1:0] pick(input logic [1:0] start,
                                      input int off);
    logic [1:0] r;
    int j;
    r = start;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = (int'(start) + off + k) % NUM_SRC;
      if (src_valid[j]) r = j[1:0];
    end
    return r;
  endfunction

  assign any  = |src_valid;
  assign nxt  = pick(act_q, 1);
  assign here = pick(act_q, 0);
  assign cur  = dat(act_q);

  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    act_d   = act_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (urgent_req) begin
          state_d = URGENT;
          ack_d   = 1'b1;
          disp_d  = clampv(urgent_data);
          we_d    = 1'b1;
          hold_d  = '0;
        end else if (any) begin
          state_d = SHOW;
          act_d   = here;
          disp_d  = dat(here);
          we_d    = 1'b1;
          dwell_d = '0;
        end
      end
      SHOW: begin
        if (urgent_req) begin
          state_d = URGENT;
          ack_d   = 1'b1;
          disp_d  = clampv(urgent_data);
          we_d    = 1'b1;
          hold_d  = '0;
        end else if (!src_valid[act_q]) begin
          if (any) begin
            act_d   = nxt;
            disp_d  = dat(nxt);
            we_d    = (dat(nxt) != disp_q);
            dwell_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (!frz && dwell_q == DW_LAST) begin
          act_d   = nxt;
          disp_d  = dat(nxt);
          we_d    = (dat(nxt) != disp_q);
          dwell_d = '0;
        end else begin
          if (!frz) dwell_d = dwell_q + 32'd1;
          if (cur != disp_q) begin
            disp_d = cur;
            we_d   = 1'b1;
          end
        end
      end
      URGENT: begin
        if (urgent_req && hold_q != '0) begin
          ack_d  = 1'b1;
          disp_d = clampv(urgent_data);
          we_d   = 1'b1;
          hold_d = '0;
        end else if (hold_q == UH_LAST) begin
          if (any) begin
            state_d = SHOW;
            act_d   = here;
            disp_d  = dat(here);
            we_d    = 1'b1;
            dwell_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == URGENT);
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      state_q <= IDLE;
      disp_q  <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      act_q   <= '0;
      dwell_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      act_q   <= act_d;
      dwell_q <= dwell_d;
      hold_q  <= hold_d;
    end
  end

  assign displayed_number = disp_q;
  assign we               = we_q;
  assign urgent_ack       = ack_q;
  assign busy_urgent      = busy_q;
  assign active_src       = act_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: reference model compared every
// cycle plus directed literal checks. Define SCHED_FREEZE_EN for freeze.
module tb_display_source_scheduler;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int UH = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [63:0] src_data = '0;
  logic        urgent_req = 1'b0;
  logic [15:0] urgent_data = '0;
`ifdef SCHED_FREEZE_EN
  logic        freeze = 1'b0;
`endif
  logic        urgent_ack;
  logic [15:0] displayed_number;
  logic        we;
  logic [1:0]  active_src;
  logic        busy_urgent;

  int n_chk = 0;
  int n_fail = 0;

  display_source_scheduler #(
    .NUM_SRC(NS), .DWELL_CYCLES(DW), .URGENT_HOLD(UH)
  ) dut (
    .clock_100Mhz(clk),
    .reset(reset),
    .src_valid(src_valid),
    .src_data(src_data),
    .urgent_req(urgent_req),
    .urgent_data(urgent_data),
`ifdef SCHED_FREEZE_EN
    .freeze(freeze),
`endif
    .urgent_ack(urgent_ack),
    .displayed_number(displayed_number),
    .we(we),
    .active_src(active_src),
    .busy_urgent(busy_urgent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode;    // 0 idle, 1 showing a source, 2 urgent
  int m_num;
  int m_we;
  int m_ack;
  int m_src;
  int m_left;    // cycles of dwell still to show
  int m_uleft;   // cycles of urgent hold still to show

  function automatic int clampi(input logic [15:0] v);
    return (v > 16'd9999) ? 9999 : int'(v);
  endfunction

  function automatic int srcval(input int i);
    return clampi(src_data[16*i +: 16]);
  endfunction

  function automatic int search(input int from);
    for (int k = 0; k < NS; k++)
      if (src_valid[(from + k) % NS]) return (from + k) % NS;
    return -1;
  endfunction

  function automatic void show(input int s, input int force_we);
    int prev;
    prev   = m_num;
    m_src  = s;
    m_num  = srcval(s);
    m_we   = (force_we != 0 || m_num != prev) ? 1 : 0;
    m_left = DW;
    m_mode = 1;
  endfunction

  function automatic void model_step();
    int s;
    bit frz;
`ifdef SCHED_FREEZE_EN
    frz = freeze;
`else
    frz = 1'b0;
`endif
    if (!reset) begin
      m_mode = 0; m_num = 0; m_we = 0; m_ack = 0;
      m_src = 0; m_left = 0; m_uleft = 0;
      return;
    end
    m_we = 0;
    m_ack = 0;
    if (urgent_req && (m_mode != 2 || m_uleft < UH)) begin
      m_mode = 2; m_num = clampi(urgent_data);
      m_we = 1; m_ack = 1; m_uleft = UH;
    end else if (m_mode == 0) begin
      s = search(m_src);
      if (s >= 0) show(s, 1);
    end else if (m_mode == 1) begin
      if (!src_valid[m_src]) begin
        s = search(m_src + 1);
        if (s < 0) m_mode = 0;
        else show(s, 0);
      end else if (!frz && m_left == 1) begin
        show(search(m_src + 1), 0);
      end else begin
        if (!frz) m_left--;
        if (srcval(m_src) != m_num) begin
          m_num = srcval(m_src);
          m_we = 1;
        end
      end
    end else begin
      if (m_uleft == 1) begin
        s = search(m_src);
        if (s >= 0) show(s, 1);
        else m_mode = 0;
      end else begin
        m_uleft--;
      end
    end
  endfunction

  // per-cycle comparison against the model
  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_num", int'(displayed_number), m_num);
    chk("m_we", int'(we), m_we);
    chk("m_ack", int'(urgent_ack), m_ack);
    chk("m_src", int'(active_src), m_src);
    chk("m_busy", int'(busy_urgent), (m_mode == 2) ? 1 : 0);
  end

  // ---------------- directed stimulus ----------------
  int vals[3];
  int gaps[3];
  int nseen;
  int last;
  int cnt;
  bit found;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_num", int'(displayed_number), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_ack", int'(urgent_ack), 0);
    chk("rst_src", int'(active_src), 0);
    chk("rst_busy", int'(busy_urgent), 0);

    // rotation across sources 0,1,3
    reset = 1'b1;
    src_valid = 4'b1011;
    src_data = {16'd40, 16'd30, 16'd20, 16'd10};
    @(negedge clk);
    chk("first_num", int'(displayed_number), 10);
    chk("first_we", int'(we), 1);
    chk("first_src", int'(active_src), 0);
    nseen = 0;
    last = 0;
    for (int c = 1; c <= 30 && nseen < 3; c++) begin
      @(negedge clk);
      if (we) begin
        vals[nseen] = int'(displayed_number);
        gaps[nseen] = c - last;
        last = c;
        nseen++;
      end
    end
    chk("rot_count", nseen, 3);
    if (nseen == 3) begin
      chk("rot_v0", vals[0], 20);
      chk("rot_v1", vals[1], 40);
      chk("rot_v2", vals[2], 10);
      chk("rot_g0", gaps[0], 8);
      chk("rot_g1", gaps[1], 8);
      chk("rot_g2", gaps[2], 8);
    end

    // sole source, clamp and live change
    src_valid = 4'b0001;
    src_data[15:0] = 16'd12345;
    @(negedge clk);
    chk("clamp_num", int'(displayed_number), 9999);
    chk("clamp_we", int'(we), 1);
    repeat (2) @(negedge clk);
    src_data[15:0] = 16'd7;
    @(negedge clk);
    chk("live_num", int'(displayed_number), 7);
    chk("live_we", int'(we), 1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (we) cnt++;
    end
    chk("solo_no_we", cnt, 0);
    chk("solo_num", int'(displayed_number), 7);

    // urgent pre-emption at dwell 3 of source 1
    src_valid = 4'b1011;
    src_data = {16'd40, 16'd30, 16'd20, 16'd10};
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (we && active_src == 2'd1) found = 1'b1;
    end
    chk("wait_src1", int'(found), 1);
    repeat (3) @(negedge clk);
    urgent_req = 1'b1;
    urgent_data = 16'd555;
    @(negedge clk);
    urgent_req = 1'b0;
    urgent_data = 16'd777;
    chk("urg_ack", int'(urgent_ack), 1);
    chk("urg_we", int'(we), 1);
    chk("urg_num", int'(displayed_number), 555);
    chk("urg_busy", int'(busy_urgent), 1);
    for (int i = 1; i < UH; i++) begin
      @(negedge clk);
      chk("urg_hold_num", int'(displayed_number), 555);
      chk("urg_hold_busy", int'(busy_urgent), 1);
    end
    @(negedge clk);
    chk("restore_num", int'(displayed_number), 20);
    chk("restore_we", int'(we), 1);
    chk("restore_busy", int'(busy_urgent), 0);
    chk("restore_src", int'(active_src), 1);
    cnt = 0;
    repeat (7) begin
      @(negedge clk);
      if (we) cnt++;
    end
    chk("restart_no_we", cnt, 0);
    @(negedge clk);
    chk("after_num", int'(displayed_number), 40);
    chk("after_src", int'(active_src), 3);

    // all sources drop: idle with value held
    src_valid = 4'b0000;
    repeat (4) begin
      @(negedge clk);
      chk("drop_num", int'(displayed_number), 40);
      chk("drop_we", int'(we), 0);
    end
    src_valid = 4'b0011;
    @(negedge clk);
    chk("wake_num", int'(displayed_number), 10);
    chk("wake_src", int'(active_src), 0);
    chk("wake_we", int'(we), 1);

`ifdef SCHED_FREEZE_EN
    src_valid = 4'b1011;
    freeze = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 8) begin
        urgent_req = 1'b1;
        urgent_data = 16'd321;
      end else begin
        urgent_req = 1'b0;
      end
      @(negedge clk);
      if (urgent_ack) cnt++;
      chk("frz_src", int'(active_src), 0);
    end
    chk("frz_ack", cnt, 1);
    freeze = 1'b0;
`endif

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
